// File: rtl/skinny_sbox_pkg.sv
// Shared sizing and types for the masked SKINNY S-box pipeline sequencer.
package skinny_sbox_pkg;

  localparam int NSTAGE_DEF = 3;
  localparam logic [NSTAGE_DEF-1:0] RND_MASK_DEF = 3'b011;

  // Width needed to count 0..nstage tokens in flight.
  function automatic int occ_w(input int nstage);
    return $clog2(nstage + 1);
  endfunction

  typedef logic [NSTAGE_DEF-1:0] stage_vec_t;

endpackage

// File: rtl/skinny_sbox_seq_ctrl_rnd_prio_arb.sv
// Fixed-priority one-hot arbiter; the highest index (oldest token) wins.
module rnd_prio_arb #(
  parameter int N = 3
) (
  input  logic [N-1:0] need,
  output logic [N-1:0] grant,
  output logic         any
);

  always_comb begin
    logic taken;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant = '0;
    taken = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      grant[i] = need[i] & ~taken;
      taken    = taken | need[i];
    end
  end

  assign any = |need;

endmodule

// File: rtl/skinny_sbox_seq_ctrl.sv
// Valid-bit sequencer for the 3-share low-latency masked SKINNY S-box pipeline.
// Optional stage zeroization is built when SBOX_STAGE_CLR_EN is defined.
module skinny_sbox_seq_ctrl
  import skinny_sbox_pkg::*;
#(
  parameter int                NSTAGE   = NSTAGE_DEF,
  parameter logic [NSTAGE-1:0] RND_MASK = RND_MASK_DEF,
  parameter int                OCC_W    = occ_w(NSTAGE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic [NSTAGE-1:0] rnd_grant,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_clr,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy
);

  logic [NSTAGE-1:0] v;
  logic [NSTAGE-1:0] src;
  logic [NSTAGE-1:0] free;
  logic [NSTAGE-1:0] cand;
  logic [NSTAGE-1:0] need;
  logic [NSTAGE-1:0] move;
  logic [NSTAGE:0]   adv;
  logic [NSTAGE-1:0] arb_grant;
  logic              arb_any;
  logic [OCC_W-1:0]  occ;
  logic              in_acc;
  logic              out_acc;

  assign src = {v[NSTAGE-2:0], in_valid};

  // adv[i+1] says the token ahead of stage i leaves this cycle; adv[NSTAGE] is the sink.
  always_comb begin
    logic higher;
    free   = '0;
    cand   = '0;
    need   = '0;
    move   = '0;
    adv    = '0;
    higher = 1'b0;
    adv[NSTAGE] = out_ready;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      free[i] = ~v[i] | adv[i+1];
      cand[i] = src[i] & free[i];
      need[i] = cand[i] & RND_MASK[i];
      move[i] = cand[i] & (~RND_MASK[i] | (need[i] & ~higher & rnd_valid));
      higher  = higher | need[i];
      adv[i]  = move[i];
    end
  end

  rnd_prio_arb #(
    .N (NSTAGE)
  ) u_arb (
    .need  (need),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign in_acc  = move[0];
  assign out_acc = v[NSTAGE-1] & out_ready;

  assign in_ready  = ~rst & free[0] & (~RND_MASK[0] | (rnd_valid & ~|need[NSTAGE-1:1]));
  assign out_valid = ~rst & v[NSTAGE-1];
  assign rnd_ready = ~rst & arb_any;
  assign rnd_grant = rst ? '0 : arb_grant;
  assign stage_en  = rst ? '0 : move;
  assign occupancy = rst ? '0 : occ;
  assign busy      = ~rst & |v;

`ifdef SBOX_STAGE_CLR_EN
  // Zeroize a stage whose token moved on with nothing behind it, so stale shares never toggle.
  assign stage_clr = rst ? '1 : (v & adv[NSTAGE:1] & ~move);
`else
  assign stage_clr = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      v   <= '0;
      occ <= '0;
    end else begin
      v <= move | (v & ~adv[NSTAGE:1]);
      unique case ({in_acc, out_acc})
        2'b10: if (occ != OCC_W'(NSTAGE)) occ <= occ + OCC_W'(1);
        2'b01: if (occ != '0) occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_sbox_seq_ctrl.sv
// Self-checking bench: token-slot model compared every cycle plus directed literal checks.
module tb_skinny_sbox_seq_ctrl;
  import skinny_sbox_pkg::*;

  localparam int N  = NSTAGE_DEF;
  localparam int OW = occ_w(N);
  localparam logic [N-1:0] M = RND_MASK_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [N-1:0]  rnd_grant;
  logic [N-1:0]  stage_en;
  logic [N-1:0]  stage_clr;
  logic [OW-1:0] occupancy;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dut_out_hs = 0;
  int dut_in_hs  = 0;
  int model_leaves = 0;
  int model_accepts = 0;

  always #5 clk = ~clk;

  skinny_sbox_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_grant (rnd_grant),
    .stage_en  (stage_en),
    .stage_clr (stage_clr),
    .occupancy (occupancy),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: each slot holds a token id or -1; tokens advance into a slot that is empty or
  // being vacated, and the single PRNG word goes to the oldest mover that needs one.
  typedef int slot_t [N];
  typedef struct {
    stage_vec_t en;
    stage_vec_t grant;
    stage_vec_t clr;
    logic       rr;
    logic       ir;
    logic       ov;
    logic       busy;
    logic       leave;
    int         occ;
  } exp_t;

  slot_t slot = '{default: -1};
  int    next_id = 0;

  function automatic exp_t model_eval();
    exp_t e;
    logic taken, ahead, dest_free, has_src;
    int   cnt;
    e.en = '0; e.grant = '0; e.clr = '0;
    e.rr = 1'b0; e.ir = 1'b0; e.ov = 1'b0; e.busy = 1'b0; e.leave = 1'b0; e.occ = 0;
    if (rst) begin
`ifdef SBOX_STAGE_CLR_EN
      e.clr = '1;
`endif
      return e;
    end
    e.leave = (slot[N-1] >= 0) && out_ready;
    taken = 1'b0;
    ahead = e.leave;
    cnt   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      dest_free = (slot[i] < 0) || ahead;
      has_src   = (i == 0) ? in_valid : (slot[(i > 0) ? i - 1 : 0] >= 0);
      if (i == 0) e.ir = dest_free && (!M[0] || (rnd_valid && !taken));
      if (has_src && dest_free) begin
        if (!M[i]) e.en[i] = 1'b1;
        else if (!taken) begin
          taken      = 1'b1;
          e.grant[i] = 1'b1;
          e.en[i]    = rnd_valid;
        end
      end
`ifdef SBOX_STAGE_CLR_EN
      e.clr[i] = (slot[i] >= 0) && ahead && !e.en[i];
`endif
      if (slot[i] >= 0) cnt++;
      ahead = e.en[i];
    end
    e.rr   = taken;
    e.ov   = slot[N-1] >= 0;
    e.occ  = cnt;
    e.busy = cnt > 0;
    return e;
  endfunction

  function automatic slot_t model_next();
    exp_t  e;
    slot_t ns;
    logic  ahead;
    e  = model_eval();
    ns = slot;
    if (rst) begin
      foreach (ns[i]) ns[i] = -1;
      return ns;
    end
    ahead = e.leave;
    for (int i = N - 1; i >= 0; i--) begin
      if (e.en[i]) ns[i] = (i == 0) ? next_id : slot[(i > 0) ? i - 1 : 0];
      else if (ahead) ns[i] = -1;
      ahead = e.en[i];
    end
    return ns;
  endfunction

  always @(posedge clk) begin
    exp_t pe;
    pe = model_eval();
    slot          <= model_next();
    next_id       <= rst ? 0 : next_id + int'(pe.en[0]);
    model_leaves  <= model_leaves + int'(pe.leave);
    model_accepts <= model_accepts + int'(pe.en[0]);
    cyc           <= cyc + 1;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    e = model_eval();
    check("stage_en",  stage_en,  e.en);
    check("rnd_grant", rnd_grant, e.grant);
    check("rnd_ready", rnd_ready, e.rr);
    check("in_ready",  in_ready,  e.ir);
    check("out_valid", out_valid, e.ov);
    check("occupancy", occupancy, e.occ);
    check("busy",      busy,      e.busy);
    check("stage_clr", stage_clr, e.clr);
    if (!rst && out_valid && out_ready) dut_out_hs++;
    if (!rst && in_valid && in_ready) dut_in_hs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
      tick();
    end
    check(name, done, 1);
    tick();
  endtask

  initial begin
    int s, acc, last_acc, k;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rnd_valid = 1'b1;

    // Reset held two cycles with in_valid high.
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_stage_en", stage_en, 0);
    check("rst_occ", occupancy, 0);
    tick();
    @(negedge clk);
    check("rst2_in_ready", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Single token walks through the three stages.
    tick(); in_valid = 1'b1;
    @(negedge clk);
    check("tok_en0", stage_en, 3'b001);
    check("tok_rr0", rnd_ready, 1);
    check("tok_gr0", rnd_grant, 3'b001);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("tok_en1", stage_en, 3'b010);
    check("tok_rr1", rnd_ready, 1);
    check("tok_gr1", rnd_grant, 3'b010);
    tick();
    @(negedge clk);
    check("tok_en2", stage_en, 3'b100);
    check("tok_rr2", rnd_ready, 0);
    tick();
    @(negedge clk);
    check("tok_out_valid", out_valid, 1);
    check("tok_occ_1", occupancy, 1);
    tick();
    @(negedge clk);
    check("tok_occ_0", occupancy, 0);
    check("tok_out_gone", out_valid, 0);
    tick();

    // Streaming eight tokens: one accept every second cycle.
    s = dut_out_hs; acc = 0; last_acc = -1; k = 0;
    in_valid = 1'b1;
    while (acc < 8 && k < 60) begin
      @(negedge clk);
      if (in_ready) begin
        if (last_acc >= 0) check("stream_gap", k - last_acc, 2);
        last_acc = k;
        acc++;
      end
      tick();
      k++;
      if (acc == 8) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("stream_accepts", acc, 8);
    drain("stream_drain");
    check("stream_outs", dut_out_hs - s, 8);

    // Back-pressure: sink stalled for ten cycles while the source keeps offering.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 9) begin
        check("bp_occ", occupancy, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_stage_en", stage_en, 0);
      end
      tick();
    end
    s = dut_out_hs;
    out_ready = 1'b1; in_valid = 1'b0;
    drain("bp_drain");
    check("bp_outs", dut_out_hs - s, 3);

    // PRNG starvation with a token sitting in stage 0.
    in_valid = 1'b1;
    @(negedge clk);
    check("starve_accept", stage_en, 3'b001);
    tick(); in_valid = 1'b0; rnd_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("starve_en", stage_en, 0);
      check("starve_rr", rnd_ready, 1);
      check("starve_gr", rnd_grant, 3'b010);
      tick();
    end
    rnd_valid = 1'b1;
    @(negedge clk);
    check("starve_release", stage_en, 3'b010);
    tick();
    drain("starve_drain");

    // Mid-flight reset with two tokens in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_occ_2", occupancy, 2);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en", stage_en, 0);
`ifdef SBOX_STAGE_CLR_EN
    check("mid_rst_clr", stage_clr, 3'b111);
`else
    check("mid_rst_clr", stage_clr, 3'b000);
`endif
    tick(); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_occ_0", occupancy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    tick();

    check("total_outs", dut_out_hs, model_leaves);
    check("total_ins", dut_in_hs, model_accepts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
